interp_coord_ctrl: RTL and testbench
====================================

INTERP_COORD_CTRL -- requirements
Module: interp_coord_ctrl

Interface
REQ-001 SHALL have parameter N_COLS, default 8, output columns per row (>=1).
REQ-002 SHALL have parameter N_ROWS, default 8, output rows per frame (>=1).
REQ-003 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port RST_SYNC_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  begin frame scan; honoured only in IDLE.
REQ-006 SHALL have port ABORT  input  1  terminate scan; return to IDLE.
REQ-007 SHALL have ports X0, Y0  input  8 each  signed origin coordinates, sampled on accepted START.
REQ-008 SHALL have ports STEP_X, STEP_Y  input  8 each  signed increments, sampled on accepted START.
REQ-009 SHALL have port READY  input  1  downstream consumed current coordinate.
REQ-010 SHALL have ports X_WE, Y_WE  output  1 each  write enables to the X and Y coordinate registers.
REQ-011 SHALL have ports X_DATA, Y_DATA  output  8 each  signed coordinates to write.
REQ-012 SHALL have port VALID  output  1  coordinate registers hold a coordinate for consumption.
REQ-013 SHALL have ports BUSY, DONE, OVF  output  1 each  scan active; end-of-frame pulse; overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, PRESENT, FIN; all outputs registered.
REQ-015 IDLE: START=1 and ABORT=0 -> LOAD; origin/steps latched; col=row=0; X_DATA=X0, Y_DATA=Y0, X_WE=Y_WE=1.
REQ-016 LOAD lasts exactly one cycle with VALID=0, then -> PRESENT; X_WE/Y_WE are one-cycle pulses, asserted only in LOAD.
REQ-017 PRESENT: VALID=1, X_DATA/Y_DATA held; stays while READY=0.
REQ-018 PRESENT with READY=1 and col<N_COLS-1 -> LOAD; X_DATA=X_DATA+STEP_X, X_WE=1 only, col+1.
REQ-019 PRESENT with READY=1, col=N_COLS-1, row<N_ROWS-1 -> LOAD; X_DATA=latched X0, Y_DATA=Y_DATA+STEP_Y, X_WE=Y_WE=1, col=0, row+1.
REQ-020 PRESENT with READY=1 on last coordinate -> FIN; FIN asserts DONE for exactly one cycle, then -> IDLE.
REQ-021 Minimum 2 cycles per coordinate; N_COLS*N_ROWS handshakes per frame, row-major.
REQ-022 BUSY=1 in LOAD, PRESENT, FIN; 0 in IDLE.
REQ-023 START outside IDLE SHALL be ignored; START and ABORT together in IDLE: stay IDLE.
REQ-024 ABORT=1 in LOAD/PRESENT/FIN -> IDLE next cycle; VALID, X_WE, Y_WE, DONE=0; no write issued; X_DATA/Y_DATA hold.
REQ-025 N_COLS=1: every handshake takes the row path; N_ROWS=1: last column goes to FIN.
REQ-026 col/row counters SHALL be sized to hold N_COLS-1/N_ROWS-1 and never exceed them.

Reset
REQ-027 RST_SYNC_N=0 at a rising edge SHALL force IDLE; X_DATA=Y_DATA=0; X_WE, Y_WE, VALID, BUSY, DONE, OVF=0; counters 0.
REQ-028 Reset mid-scan SHALL take priority over START, ABORT, READY; no write pulse in the following cycle.

Configuration
REQ-029 Macro COORD_SAT_EN defined: coordinate additions saturate to [-128,127]; OVF set on any clamp, sticky until next accepted START or reset.
REQ-030 COORD_SAT_EN undefined: additions wrap modulo 2^8 (two's complement); OVF tied 0.

Verification
REQ-031 N_COLS=3, N_ROWS=2, X0=0, Y0=-4, STEP_X=2, STEP_Y=3, READY=1 -> VALID coords (0,-4),(2,-4),(4,-4),(0,-1),(2,-1),(4,-1); Y_WE only on 1st and 4th; DONE 1 cycle after 6th handshake; 12 cycles START-accept to FIN.
REQ-032 Same config, READY=0 for 5 cycles in 2nd PRESENT -> VALID, (2,-4) held 5 cycles, no WE pulse, then resumes.
REQ-033 X0=120, STEP_X=5, N_COLS=3 -> without COORD_SAT_EN X: 120,125,-126, OVF=0; with it X: 120,125,127, OVF=1 until next START.
REQ-034 ABORT in PRESENT of 3rd coordinate -> next cycle IDLE, BUSY=0, no DONE; new START restarts at (X0,Y0).
REQ-035 RST_SYNC_N=0 for 1 cycle mid-LOAD -> all outputs 0 next cycle, IDLE; START during PRESENT ignored.

Source files
------------

// File: rtl/interp_coord_ctrl.sv
// Row-major coordinate scan controller: writes X/Y coordinate registers, then holds VALID until READY.
// Build option COORD_SAT_EN: coordinate additions saturate to [-128,127] and clamps set a sticky OVF.
module interp_coord_ctrl #(
    parameter int N_COLS = 8,
    parameter int N_ROWS = 8
) (
    input  logic       CLK,
    input  logic       RST_SYNC_N,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] X0,
    input  logic [7:0] Y0,
    input  logic [7:0] STEP_X,
    input  logic [7:0] STEP_Y,
    input  logic       READY,
    output logic       X_WE,
    output logic       Y_WE,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic       VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVF
);

    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, FIN} state_t;

    // Result is {clamped, sum}; operands are two's-complement coordinates.
`ifdef COORD_SAT_EN
    function automatic logic [8:0] add_coord(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) return {1'b1, (s[8] ? 8'h80 : 8'h7F)};
        return {1'b0, s[7:0]};
    endfunction
`else
    function automatic logic [8:0] add_coord(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a + b};
    endfunction
`endif

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [7:0]       x0_q, step_x_q, step_y_q;
    logic [7:0]       x_data_q, y_data_q;
    logic             x_we_q, y_we_q, valid_q, busy_q, done_q, ovf_q;
    logic [8:0]       x_sum_d, y_sum_d;

    always_comb begin
        x_sum_d = add_coord(x_data_q, step_x_q);
        y_sum_d = add_coord(y_data_q, step_y_q);
    end

    // NOTE: all state here is sequential, so only non-blocking assignments; mixing in blocking ones creates simulation/synthesis ordering mismatches.
    always_ff @(posedge CLK) begin
        if (!RST_SYNC_N) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            x0_q     <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            x_data_q <= '0;
            y_data_q <= '0;
            x_we_q   <= 1'b0;
            y_we_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle so every path below only has to raise them.
            x_we_q <= 1'b0;
            y_we_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START && !ABORT) begin
                        state_q  <= LOAD;
                        x0_q     <= X0;
                        step_x_q <= STEP_X;
                        step_y_q <= STEP_Y;
                        x_data_q <= X0;
                        y_data_q <= Y0;
                        x_we_q   <= 1'b1;
                        y_we_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        col_q    <= '0;
                        row_q    <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ABORT) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (ABORT) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (READY) begin
                        valid_q <= 1'b0;
                        if (col_q != COL_LAST) begin
                            state_q  <= LOAD;
                            col_q    <= col_q + 1'b1;
                            x_data_q <= x_sum_d[7:0];
                            x_we_q   <= 1'b1;
                            ovf_q    <= ovf_q | x_sum_d[8];
                        end else if (row_q != ROW_LAST) begin
                            // Row wrap: X returns to the latched origin, Y advances.
                            state_q  <= LOAD;
                            col_q    <= '0;
                            row_q    <= row_q + 1'b1;
                            x_data_q <= x0_q;
                            y_data_q <= y_sum_d[7:0];
                            x_we_q   <= 1'b1;
                            y_we_q   <= 1'b1;
                            ovf_q    <= ovf_q | y_sum_d[8];
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign X_WE   = x_we_q;
    assign Y_WE   = y_we_q;
    assign X_DATA = x_data_q;
    assign Y_DATA = y_data_q;
    assign VALID  = valid_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_interp_coord_ctrl.sv
// Scoreboard bench for interp_coord_ctrl (3x2 frame): stimulus pushes hand-computed writes/coordinates, a negedge monitor pops and compares.
module tb_interp_coord_ctrl;

    localparam int N_COLS  = 3;
    localparam int N_ROWS  = 2;
    localparam int N_COORD = N_COLS * N_ROWS;

`ifdef COORD_SAT_EN
    localparam int SAT_X3  = 127;
    localparam int SAT_OVF = 1;
`else
    localparam int SAT_X3  = -126;
    localparam int SAT_OVF = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST_SYNC_N = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       READY = 1'b0;
    logic [7:0] X0 = '0, Y0 = '0, STEP_X = '0, STEP_Y = '0;
    logic       X_WE, Y_WE, VALID, BUSY, DONE, OVF;
    logic [7:0] X_DATA, Y_DATA;

    typedef struct { int x; int y; int xwe; int ywe; } wr_t;
    typedef struct { int x; int y; } xy_t;

    wr_t wr_q[$];
    xy_t coord_q[$];
    int  done_q[$];
    wr_t mon_wr;
    xy_t mon_xy;
    int  mon_done;
    logic valid_prev = 1'b0;

    int passed = 0;
    int total  = 0;

    // Hand-computed frames: A = origin (0,-4), step (2,3); S = origin (120,0), step (5,0).
    int a_x[N_COORD] = '{0, 2, 4, 0, 2, 4};
    int a_y[N_COORD] = '{-4, -4, -4, -1, -1, -1};
    int s_x[N_COORD] = '{120, 125, SAT_X3, 120, 125, SAT_X3};
    int s_y[N_COORD] = '{0, 0, 0, 0, 0, 0};
    int ywe_pat[N_COORD] = '{1, 0, 0, 1, 0, 0};

    interp_coord_ctrl #(.N_COLS(N_COLS), .N_ROWS(N_ROWS)) dut (
        .CLK(CLK), .RST_SYNC_N(RST_SYNC_N), .START(START), .ABORT(ABORT),
        .X0(X0), .Y0(Y0), .STEP_X(STEP_X), .STEP_Y(STEP_Y), .READY(READY),
        .X_WE(X_WE), .Y_WE(Y_WE), .X_DATA(X_DATA), .Y_DATA(Y_DATA),
        .VALID(VALID), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input int x0, input int y0, input int sx, input int sy);
        X0 = 8'(x0);
        Y0 = 8'(y0);
        STEP_X = 8'(sx);
        STEP_Y = 8'(sy);
    endtask

    task automatic push_frame(input int xs[N_COORD], input int ys[N_COORD],
                              input int n_wr, input int n_coord, input bit full);
        for (int i = 0; i < n_wr; i++)
            wr_q.push_back('{x: xs[i], y: ys[i], xwe: 1, ywe: ywe_pat[i]});
        for (int i = 0; i < n_coord; i++)
            coord_q.push_back('{x: xs[i], y: ys[i]});
        if (full) done_q.push_back(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_we"}, X_WE, 0);
        check({tag, "_y_we"}, Y_WE, 0);
        check({tag, "_x_data"}, X_DATA, 0);
        check({tag, "_y_data"}, Y_DATA, 0);
        check({tag, "_valid"}, VALID, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_ovf"}, OVF, 0);
    endtask

    task automatic start_frame();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("ovf_clear_on_start", OVF, 0);
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!VALID && guard < 10) begin
            tick();
            guard++;
        end
        check("valid_wait", VALID, 1);
    endtask

    // Serve n handshakes; coordinate stall_idx is held with READY=0 for stall_len cycles.
    task automatic serve(input int n, input int stall_idx, input int stall_len);
        for (int i = 0; i < n; i++) begin
            wait_valid();
            if (!VALID) return;
            if (i == stall_idx) begin
                for (int k = 0; k < stall_len; k++) begin
                    check("stall_valid", VALID, 1);
                    check("stall_x_hold", $signed(X_DATA), a_x[i]);
                    tick();
                end
            end
            READY = 1'b1;
            tick();
            READY = 1'b0;
        end
    endtask

    task automatic finish_frame(input int exp_ovf);
        check("done_pulse", DONE, 1);
        check("busy_in_fin", BUSY, 1);
        check("ovf_at_fin", OVF, exp_ovf);
        tick();
        check("done_one_cycle", DONE, 0);
        check("idle_after_fin", BUSY, 0);
    endtask

    always @(negedge CLK) begin
        if (X_WE || Y_WE) begin
            check("wr_expected", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                mon_wr = wr_q.pop_front();
                check("wr_x_we", X_WE, mon_wr.xwe);
                check("wr_y_we", Y_WE, mon_wr.ywe);
                check("wr_x_data", $signed(X_DATA), mon_wr.x);
                check("wr_y_data", $signed(Y_DATA), mon_wr.y);
            end
        end
        if (VALID && !valid_prev) begin
            check("coord_expected", int'(coord_q.size() > 0), 1);
            if (coord_q.size() > 0) begin
                mon_xy = coord_q.pop_front();
                check("coord_x", $signed(X_DATA), mon_xy.x);
                check("coord_y", $signed(Y_DATA), mon_xy.y);
            end
        end
        if (DONE) begin
            check("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) mon_done = done_q.pop_front();
        end
        valid_prev = VALID;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST_SYNC_N = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        RST_SYNC_N = 1'b1;
        tick();

        // START together with ABORT in IDLE is ignored.
        set_cfg(0, -4, 2, 3);
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check("start_abort_stay_idle", BUSY, 0);

        // Full frame, READY always granted.
        push_frame(a_x, a_y, N_COORD, N_COORD, 1'b1);
        start_frame();
        serve(N_COORD, -1, 0);
        finish_frame(0);

        // Second coordinate stalled for 5 cycles.
        push_frame(a_x, a_y, N_COORD, N_COORD, 1'b1);
        start_frame();
        serve(N_COORD, 1, 5);
        finish_frame(0);

        // X crosses +127 on the third column of each row.
        set_cfg(120, 0, 5, 0);
        push_frame(s_x, s_y, N_COORD, N_COORD, 1'b1);
        start_frame();
        serve(N_COORD, -1, 0);
        finish_frame(SAT_OVF);
        tick();
        check("ovf_sticky_idle", OVF, SAT_OVF);

        // ABORT while the third coordinate is presented, then restart.
        set_cfg(0, -4, 2, 3);
        push_frame(a_x, a_y, 3, 3, 1'b0);
        start_frame();
        serve(2, -1, 0);
        wait_valid();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_valid", VALID, 0);
        check("abort_done", DONE, 0);
        check("abort_x_hold", $signed(X_DATA), 4);
        check("abort_y_hold", $signed(Y_DATA), -4);
        tick();
        push_frame(a_x, a_y, N_COORD, N_COORD, 1'b1);
        start_frame();
        serve(N_COORD, -1, 0);
        finish_frame(0);

        // Reset asserted during the first LOAD.
        push_frame(a_x, a_y, 1, 0, 1'b0);
        START = 1'b1;
        tick();
        START = 1'b0;
        RST_SYNC_N = 1'b0;
        tick();
        RST_SYNC_N = 1'b1;
        check_reset_outputs("midload_reset");
        tick();
        check("idle_after_reset", BUSY, 0);

        // START during PRESENT is ignored and the frame continues.
        push_frame(a_x, a_y, N_COORD, N_COORD, 1'b1);
        start_frame();
        wait_valid();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_in_present_valid", VALID, 1);
        check("start_in_present_x", $signed(X_DATA), 0);
        serve(N_COORD, -1, 0);
        finish_frame(0);

        tick();
        check("wr_queue_drained", wr_q.size(), 0);
        check("coord_queue_drained", coord_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
